pipe_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. Merges stall requests from ID (load-use), EX (multi-cycle divide) and MEM (data-bus wait) into the 6-bit stall vector consumed by the PC and every inter-stage register, including MEM/WB. Raises the pipeline flush and redirect PC for exceptions. Adds a data-bus watchdog: a MEM wait longer than TIMEOUT cycles is aborted and converted into a bus-timeout exception. Also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/sat_counter.sv | 29 ++
 rtl/pipe_stall_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: stall vectors,
// controller states, stall-bit positions and the default exception vector.
package pipe_ctrl_pkg;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_IDX = 2;
   localparam int STALL_EXX = 3;
   localparam int STALL_MM  = 4;
   localparam int STALL_WB  = 5;

   localparam logic [31:0] EXC_VEC_DEFAULT = 32'hBFC00380;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      ABORT   = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment)
// and synchronous active-low reset.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt,
   output logic         o_sat
);

   logic [W-1:0] r_cnt;

   assign o_sat = &r_cnt;
   assign o_cnt = r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !o_sat) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: merges ID/EX/MEM stall requests, raises
// exception flushes, aborts over-long MEM waits and counts stalled cycles.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int          TIMEOUT = 255,
   parameter int          CNT_W   = 32,
   parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             stallreq_mem,
   input  logic             exc_req,
   input  logic [31:0]      exc_pc,
   input  logic             stall_cnt_clr,
   output logic [5:0]       stall,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic             timeout_exc,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WC_W = $clog2(TIMEOUT + 1);

   ctrl_state_t r_state;
   ctrl_state_t w_state_nxt;
   logic [WC_W-1:0] r_wait_cnt;
   logic [WC_W-1:0] w_wait_nxt;

   logic        w_mem_eff;
   logic        w_timeout;
   logic [5:0]  w_stall;
   logic        w_flush;
   logic [31:0] w_new_pc;
   logic        w_tout;
   logic [CNT_W-1:0] w_cnt;
   logic        w_cnt_sat;

   // Once a wait has been aborted the bus request is ignored until it drops.
   assign w_mem_eff = stallreq_mem && (r_state != ABORT);
   assign w_timeout = w_mem_eff && (r_wait_cnt == WC_W'(TIMEOUT));

   always_comb begin
      w_stall     = STALL_NONE;
      w_flush     = 1'b0;
      w_new_pc    = 32'h0;
      w_tout      = 1'b0;
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      if (w_timeout) begin
         w_flush     = 1'b1;
         w_new_pc    = EXC_VEC;
         w_tout      = 1'b1;
         w_state_nxt = ABORT;
         w_wait_nxt  = '0;
      end else if (exc_req) begin
         w_flush     = 1'b1;
         w_new_pc    = exc_pc;
         w_wait_nxt  = '0;
         w_state_nxt = stallreq_mem ? ABORT : RUN;
      end else if (w_mem_eff) begin
         w_stall     = STALL_MEM;
         w_wait_nxt  = r_wait_cnt + 1'b1;
         w_state_nxt = MEMWAIT;
      end else begin
         w_wait_nxt = '0;
         if (r_state == ABORT) begin
            w_state_nxt = stallreq_mem ? ABORT : RUN;
         end else begin
            w_state_nxt = RUN;
         end
         if (stallreq_ex) begin
            w_stall = STALL_EX;
         end else if (stallreq_id) begin
            w_stall = STALL_ID;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   // Reset masks every output, including requests arriving during reset.
   assign stall       = rst_n ? w_stall  : STALL_NONE;
   assign flush       = rst_n & w_flush;
   assign new_pc      = rst_n ? w_new_pc : 32'h0;
   assign timeout_exc = rst_n & w_tout;
   assign stall_cnt   = rst_n ? w_cnt    : '0;

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (stall_cnt_clr),
      .i_inc ((stall != STALL_NONE) && !w_cnt_sat),
      .o_cnt (w_cnt),
      .o_sat (w_cnt_sat)
   );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl (TIMEOUT=4, CNT_W=3): directed
// scenarios followed by randomized traffic against a rule-level model.
module tb_pipe_stall_ctrl;

   localparam int          TIMEOUT = 4;
   localparam int          CNT_W   = 3;
   localparam logic [31:0] EXC_VEC = 32'hBFC00380;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      logic [5:0]       stall;
      logic             flush;
      logic [31:0]      newPc;
      logic             tout;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             stallreq_id = 1'b0;
   logic             stallreq_ex = 1'b0;
   logic             stallreq_mem = 1'b0;
   logic             exc_req = 1'b0;
   logic [31:0]      exc_pc = 32'h0;
   logic             stall_cnt_clr = 1'b0;
   logic [5:0]       stall;
   logic             flush;
   logic [31:0]      new_pc;
   logic             timeout_exc;
   logic [CNT_W-1:0] stall_cnt;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   bit   stimDone = 1'b0;

   // Reference model state: length of the current bus wait, whether the
   // current bus transaction has been abandoned, and the stall tally.
   int   memRun = 0;
   bit   aborted = 1'b0;
   int   cntModel = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W),
      .EXC_VEC (EXC_VEC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stallreq_id   (stallreq_id),
      .stallreq_ex   (stallreq_ex),
      .stallreq_mem  (stallreq_mem),
      .exc_req       (exc_req),
      .exc_pc        (exc_pc),
      .stall_cnt_clr (stall_cnt_clr),
      .stall         (stall),
      .flush         (flush),
      .new_pc        (new_pc),
      .timeout_exc   (timeout_exc),
      .stall_cnt     (stall_cnt)
   );

   task automatic applyStimulus(input bit rst, input bit id, input bit ex,
                                input bit mem, input bit exc,
                                input logic [31:0] pc, input bit clr);
      exp_t e;
      bit   memEff;
      @(posedge clk);
      #1;
      rst_n         = ~rst;
      stallreq_id   = id;
      stallreq_ex   = ex;
      stallreq_mem  = mem;
      exc_req       = exc;
      exc_pc        = pc;
      stall_cnt_clr = clr;
      e.stall = 6'b000000;
      e.flush = 1'b0;
      e.newPc = 32'h0;
      e.tout  = 1'b0;
      e.cnt   = rst ? '0 : CNT_W'(cntModel);
      if (rst) begin
         memRun   = 0;
         aborted  = 1'b0;
         cntModel = 0;
      end else begin
         memEff = mem && !aborted;
         if (memEff && memRun == TIMEOUT) begin
            e.flush = 1'b1;
            e.newPc = EXC_VEC;
            e.tout  = 1'b1;
            aborted = 1'b1;
            memRun  = 0;
         end else if (exc) begin
            e.flush = 1'b1;
            e.newPc = pc;
            memRun  = 0;
            aborted = mem;
         end else begin
            if (memEff)   e.stall = 6'b011111;
            else if (ex)  e.stall = 6'b001111;
            else if (id)  e.stall = 6'b000111;
            memRun = memEff ? memRun + 1 : 0;
            if (!mem) aborted = 1'b0;
         end
         if (clr) cntModel = 0;
         else if (e.stall != 6'b000000 && cntModel < CNT_MAX) cntModel++;
      end
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   int memStreak = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("stall",       {26'h0, stall},        {26'h0, e.stall});
            checkOutput("flush",       {31'h0, flush},        {31'h0, e.flush});
            checkOutput("new_pc",      new_pc,                e.newPc);
            checkOutput("timeout_exc", {31'h0, timeout_exc},  {31'h0, e.tout});
            checkOutput("stall_cnt",   32'(stall_cnt),        32'(e.cnt));
            memStreak = (stall == 6'b011111) ? memStreak + 1 : 0;
            if (memStreak > 0)
               checkOutput("mem_stall_bound", {31'h0, memStreak > TIMEOUT}, 32'h0);
         end
      end
   end

   initial begin
      bit memSticky;
      int drain;
      // Reset with every request raised
      repeat (3) applyStimulus(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      // Priority ladder
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 1, 0, 0, 0);
      applyStimulus(0, 1, 1, 1, 1, 32'h8000_0180, 0);
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0);
      // Watchdog: 8 cycles of wait, drop, reassert
      repeat (8) applyStimulus(0, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0);
      // Timeout beats a simultaneous exception
      for (int i = 0; i < 8; i++)
         applyStimulus(0, 0, 0, 1, (i == 4), 32'h1234_5678, 0);
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0);
      // Waits that finish before the watchdog fires
      repeat (3) applyStimulus(0, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (4) applyStimulus(0, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      // Counter saturation and clear while stalled
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      repeat (10) applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 1);
      repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0);
      // Randomized traffic with long-lived bus waits
      memSticky = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 4) == 0) memSticky = ~memSticky;
         applyStimulus($urandom_range(0, 99) == 0,
                       $urandom_range(0, 2) == 0,
                       $urandom_range(0, 3) == 0,
                       memSticky,
                       $urandom_range(0, 19) == 0,
                       $urandom,
                       $urandom_range(0, 29) == 0);
      end
      stimDone = 1'b1;
      drain = 0;
      while (expQ.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      @(posedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain actual=%0d required=0 pending", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
